minicpu_mc_top: RTL

- Multicycle successor to the single-cycle miniCPU core. It implements a LoongArch32 subset over variable-latency instruction and data SRAM ports that use a req/rvalid handshake.
- Each instruction walks an FSM: IF → EX → (MEM) → WB.
- Adds SUB.W, LU12I.W, BEQ, B and BL, plus a per-instruction debug writeback trace for golden-trace comparison.
- Sits between the SoC SRAM wrappers and the trace checker.

---
 rtl/minicpu_mc_pkg.sv | 25 ++
 rtl/minicpu_regfile.sv | 27 ++
 rtl/minicpu_mc_top.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/minicpu_mc_pkg.sv
// Shared definitions for the multicycle miniCPU: FSM states, opcode match
// constants and the default reset vector.
package minicpu_mc_pkg;

  typedef enum logic [1:0] {
    S_IF,
    S_EX,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

  localparam logic [16:0] OP_ADD_W   = 17'h00020;
  localparam logic [16:0] OP_SUB_W   = 17'h00022;
  localparam logic [9:0]  OP_ADDI_W  = 10'h00a;
  localparam logic [9:0]  OP_LD_W    = 10'h0a2;
  localparam logic [9:0]  OP_ST_W    = 10'h0a6;
  localparam logic [6:0]  OP_LU12I_W = 7'h0a;
  localparam logic [5:0]  OP_BEQ     = 6'h16;
  localparam logic [5:0]  OP_BNE     = 6'h17;
  localparam logic [5:0]  OP_B       = 6'h14;
  localparam logic [5:0]  OP_BL      = 6'h15;

endpackage

// File: rtl/minicpu_regfile.sv
// General-purpose register file: two asynchronous reads, one synchronous write.
// Register 0 always reads zero and silently drops writes.
module minicpu_regfile #(
  parameter int unsigned NREGS_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [NREGS_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [NREGS_LOG2-1:0] raddr1,
  output logic [31:0]           rdata1,
  input  logic [NREGS_LOG2-1:0] raddr2,
  output logic [31:0]           rdata2
);

  logic [31:0] regs [0:(1 << NREGS_LOG2) - 1];

  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/minicpu_mc_top.sv
// Multicycle LoongArch32-subset core (IF -> EX -> [MEM] -> WB) over req/rvalid
// instruction and data SRAM ports, with a per-instruction writeback trace.
module minicpu_mc_top
  import minicpu_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned NREGS_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_rvalid,
  input  logic [31:0] inst_sram_rdata,
  output logic        data_sram_req,
  output logic        data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_rvalid,
  input  logic [31:0] data_sram_rdata,
  output logic        debug_wb_valid,
  output logic [31:0] debug_wb_pc,
  output logic        debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] ir;

  logic [4:0]  f_rd, f_rj, f_rk, f_r2;
  logic [31:0] rj_val, r2_val;
  logic [31:0] simm12, offs16, offs26;
  logic        is_add, is_sub, is_addi, is_ld, is_st, is_lu12i;
  logic        is_beq, is_bne, is_b, is_bl;

  logic [31:0] ex_res, ex_npc;
  logic        ex_we;
  logic [4:0]  ex_wnum;

  assign f_rd = ir[4:0];
  assign f_rj = ir[9:5];
  assign f_rk = ir[14:10];

  assign is_add   = (ir[31:15] == OP_ADD_W);
  assign is_sub   = (ir[31:15] == OP_SUB_W);
  assign is_addi  = (ir[31:22] == OP_ADDI_W);
  assign is_ld    = (ir[31:22] == OP_LD_W);
  assign is_st    = (ir[31:22] == OP_ST_W);
  assign is_lu12i = (ir[31:25] == OP_LU12I_W);
  assign is_beq   = (ir[31:26] == OP_BEQ);
  assign is_bne   = (ir[31:26] == OP_BNE);
  assign is_b     = (ir[31:26] == OP_B);
  assign is_bl    = (ir[31:26] == OP_BL);

  // Stores and conditional branches read rd through the second port instead of rk.
  assign f_r2 = (is_st || is_beq || is_bne) ? f_rd : f_rk;

  assign simm12 = {{20{ir[21]}}, ir[21:10]};
  assign offs16 = {{14{ir[25]}}, ir[25:10], 2'b00};
  assign offs26 = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};

  minicpu_regfile #(
    .NREGS_LOG2(NREGS_LOG2)
  ) u_regfile (
    .clk    (clk),
    .we     (debug_wb_valid && debug_wb_rf_we),
    .waddr  (debug_wb_rf_wnum[NREGS_LOG2-1:0]),
    .wdata  (debug_wb_rf_wdata),
    .raddr1 (f_rj[NREGS_LOG2-1:0]),
    .rdata1 (rj_val),
    .raddr2 (f_r2[NREGS_LOG2-1:0]),
    .rdata2 (r2_val)
  );

  always_comb begin
    ex_res  = '0;
    ex_we   = 1'b0;
    ex_wnum = f_rd;
    ex_npc  = pc + 32'd4;
    if (is_add) begin
      ex_res = rj_val + r2_val;
      ex_we  = 1'b1;
    end else if (is_sub) begin
      ex_res = rj_val - r2_val;
      ex_we  = 1'b1;
    end else if (is_addi) begin
      ex_res = rj_val + simm12;
      ex_we  = 1'b1;
    end else if (is_ld) begin
      ex_we  = 1'b1;
    end else if (is_lu12i) begin
      ex_res = {ir[24:5], 12'b0};
      ex_we  = 1'b1;
    end else if (is_beq) begin
      if (rj_val == r2_val) ex_npc = pc + offs16;
    end else if (is_bne) begin
      if (rj_val != r2_val) ex_npc = pc + offs16;
    end else if (is_b) begin
      ex_npc = pc + offs26;
    end else if (is_bl) begin
      ex_npc  = pc + offs26;
      ex_res  = pc + 32'd4;
      ex_we   = 1'b1;
      ex_wnum = 5'd1;
    end
  end

  assign inst_sram_addr = pc;

  // The trace registers double as the writeback stage: the regfile is written
  // from them during the single cycle debug_wb_valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IF;
      pc                <= RESET_PC;
      npc               <= RESET_PC;
      ir                <= '0;
      inst_sram_req     <= 1'b0;
      data_sram_req     <= 1'b0;
      data_sram_we      <= 1'b0;
      data_sram_addr    <= '0;
      data_sram_wdata   <= '0;
      debug_wb_valid    <= 1'b0;
      debug_wb_pc       <= '0;
      debug_wb_rf_we    <= 1'b0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      debug_wb_valid <= 1'b0;
      case (state)
        S_IF: begin
          if (!inst_sram_req) begin
            inst_sram_req <= 1'b1;
          end else if (inst_sram_rvalid) begin
            ir            <= inst_sram_rdata;
            inst_sram_req <= 1'b0;
            state         <= S_EX;
          end
        end
        S_EX: begin
          npc               <= ex_npc;
          debug_wb_pc       <= pc;
          debug_wb_rf_we    <= ex_we && (ex_wnum != '0);
          debug_wb_rf_wnum  <= ex_wnum;
          debug_wb_rf_wdata <= ex_res;
          if (is_ld || is_st) begin
            data_sram_req   <= 1'b1;
            data_sram_we    <= is_st;
            data_sram_addr  <= rj_val + simm12;
            data_sram_wdata <= r2_val;
            state           <= S_MEM;
          end else begin
            debug_wb_valid <= 1'b1;
            state          <= S_WB;
          end
        end
        S_MEM: begin
          if (data_sram_req && data_sram_rvalid) begin
            if (!data_sram_we) debug_wb_rf_wdata <= data_sram_rdata;
            data_sram_req  <= 1'b0;
            data_sram_we   <= 1'b0;
            debug_wb_valid <= 1'b1;
            state          <= S_WB;
          end
        end
        S_WB: begin
          pc            <= npc;
          inst_sram_req <= 1'b1;
          state         <= S_IF;
        end
        default: state <= S_IF;
      endcase
    end
  end

endmodule
